pll_lock_sequencer: RTL and testbench

- Sequences the rPLL reset and lock-qualification for the USB HS clocking path.
- Runs on the 27 MHz crystal clock (clkin); drives the PLL RESET input and watches the asynchronous PLL LOCK output.
- Retries the PLL on lock timeout and reports failure after repeated timeouts.
- Holds the system reset until lock is stable; re-sequences the PLL on lock loss or on software request.

---
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer on the crystal clock.
// Holds the PLL and system in reset until lock is stable; retries on timeout, latches FAIL after repeated timeouts.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES          = 27,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync1_q, sync2_q;
    logic             pll_reset_q, sys_rst_q, ready_q, fail_q, lost_q, lost_d;

    logic             lock_sync;
    logic             timeout;
    logic [3:0]       retry_inc;

    assign lock_sync = sync2_q;
    assign timeout   = ((state_q == S_WAIT) || (state_q == S_STABLE)) &&
                       (tcnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
    assign retry_inc = retry_q + 4'd1;

    // Priority: restart, then timeout, then lock loss / stable completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        if (restart) begin
            state_d = S_RST;
            cnt_d   = '0;
            tcnt_d  = '0;
            retry_d = '0;
        end else if (timeout) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            tcnt_d  = '0;
            state_d = (retry_inc == 4'(MAX_RETRIES)) ? S_FAIL : S_RST;
        end else begin
            case (state_q)
                S_RST: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (lock_sync) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end
                end
                S_STABLE: begin
                    tcnt_d = tcnt_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (!lock_sync) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_sync) begin
                        lost_d  = 1'b1;
                        state_d = S_RST;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Outputs decode state_d so they switch on the same edge as state_q.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_RST;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == S_RST) || (state_d == S_FAIL);
            sys_rst_q   <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
            lost_q      <= lost_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign lock_lost   = lost_q;
    assign retry_cnt   = retry_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle parameters (4/8/32/2).
module tb_pll_lock_sequencer;

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst, ready, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2),
    .CNT_W(16)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .restart(restart),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .sys_rst(sys_rst),
    .ready(ready),
    .fail(fail),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .dbg_state_o(dbg_state)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_lock = 1'b1;
    restart = 1'b0;
    repeat (3) tick();
    checks++;
    if ({dbg_state, pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt} !== {ST_RST, 5'b11000, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: state=%0d pr=%b sr=%b rdy=%b fail=%b ll=%b retry=%0d expected state=0 pr=1 sr=1 rdy=0 fail=0 ll=0 retry=0",
               dbg_state, pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt);
    end
  endtask

  task automatic test_lock_up();
    int fall_at = 0, stable_at = 0, rise_at = 0;
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!pll_reset && fall_at == 0) fall_at = i;
      if (dbg_state == ST_STABLE && stable_at == 0) stable_at = i;
      if (ready && rise_at == 0) rise_at = i;
    end
    checks++;
    if (fall_at !== 4) begin errors++; $display("FAIL lockup_pll_reset_len: fell at %0d expected 4", fall_at); end
    checks++;
    if (stable_at !== 5) begin errors++; $display("FAIL lockup_stable_entry: at %0d expected 5", stable_at); end
    checks++;
    if (rise_at !== 13) begin errors++; $display("FAIL lockup_ready: at %0d expected 13", rise_at); end
    checks++;
    if ({sys_rst, retry_cnt, dbg_state} !== {1'b0, 4'd0, ST_RUN}) begin
      errors++;
      $display("FAIL lockup_run: sr=%b retry=%0d state=%0d expected sr=0 retry=0 state=3", sys_rst, retry_cnt, dbg_state);
    end
  endtask

  task automatic test_glitch();
    int rise_at = 0;
    pll_lock = 1'b1;
    pulse_restart();
    repeat (10) tick();
    checks++;
    if (dbg_state !== ST_STABLE) begin errors++; $display("FAIL glitch_stable: state=%0d expected 2", dbg_state); end
    pll_lock = 1'b0;
    repeat (3) tick();
    checks++;
    if ({dbg_state, ready} !== {ST_WAIT, 1'b0}) begin
      errors++;
      $display("FAIL glitch_back_to_wait: state=%0d rdy=%b expected state=1 rdy=0", dbg_state, ready);
    end
    pll_lock = 1'b1;
    for (int i = 14; i <= 30; i++) begin
      tick();
      if (ready && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 24) begin errors++; $display("FAIL glitch_ready: at %0d expected 24", rise_at); end
  endtask

  task automatic test_lock_loss();
    int rise_at = 0;
    pll_lock = 1'b0;
    repeat (2) tick();
    checks++;
    if ({ready, lock_lost} !== 2'b10) begin
      errors++;
      $display("FAIL loss_latency: rdy=%b ll=%b expected rdy=1 ll=0", ready, lock_lost);
    end
    tick();
    checks++;
    if ({lock_lost, pll_reset, sys_rst, ready, dbg_state} !== {4'b1110, ST_RST}) begin
      errors++;
      $display("FAIL loss_pulse: ll=%b pr=%b sr=%b rdy=%b state=%0d expected ll=1 pr=1 sr=1 rdy=0 state=0",
               lock_lost, pll_reset, sys_rst, ready, dbg_state);
    end
    tick();
    checks++;
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_single_cycle: ll=%b expected 0", lock_lost); end
    pll_lock = 1'b1;
    for (int k = 2; k <= 25; k++) begin
      tick();
      if (ready && rise_at == 0) rise_at = k;
    end
    checks++;
    if (rise_at !== 13) begin errors++; $display("FAIL loss_resequence: ready at %0d expected 13", rise_at); end
    checks++;
    if (retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_retry: retry=%0d expected 0", retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    int wait_at = 0, retry1_at = 0, fail_at = 0;
    logic pr36 = 1'b0;
    pll_lock = 1'b0;
    pulse_restart();
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (dbg_state == ST_WAIT && wait_at == 0) wait_at = k;
      if (retry_cnt == 4'd1 && retry1_at == 0) retry1_at = k;
      if (fail && fail_at == 0) fail_at = k;
      if (k == 36) pr36 = pll_reset;
    end
    checks++;
    if (wait_at !== 4) begin errors++; $display("FAIL timeout_wait_entry: at %0d expected 4", wait_at); end
    checks++;
    if ({retry1_at, pr36} !== {32'd36, 1'b1}) begin
      errors++;
      $display("FAIL timeout_first: retry1 at %0d pr=%b expected 36 pr=1", retry1_at, pr36);
    end
    checks++;
    if (fail_at !== 72) begin errors++; $display("FAIL timeout_fail_entry: at %0d expected 72", fail_at); end
    checks++;
    if ({fail, pll_reset, sys_rst, ready, retry_cnt, dbg_state} !== {4'b1110, 4'd2, ST_FAIL}) begin
      errors++;
      $display("FAIL timeout_fail_state: fail=%b pr=%b sr=%b rdy=%b retry=%0d state=%0d expected 1 1 1 0 2 4",
               fail, pll_reset, sys_rst, ready, retry_cnt, dbg_state);
    end
  endtask

  task automatic test_restart();
    int fall_at = 0;
    int fall2_at = 0;
    logic saw_fail = 1'b0;
    pulse_restart();
    checks++;
    if ({dbg_state, retry_cnt, fail, pll_reset} !== {ST_RST, 4'd0, 2'b01}) begin
      errors++;
      $display("FAIL restart_from_fail: state=%0d retry=%0d fail=%b pr=%b expected 0 0 0 1", dbg_state, retry_cnt, fail, pll_reset);
    end
    for (int k = 1; k <= 71; k++) begin
      tick();
      if (!pll_reset && fall_at == 0) fall_at = k;
    end
    checks++;
    if (fall_at !== 4) begin errors++; $display("FAIL restart_rst_len: fell at %0d expected 4", fall_at); end
    checks++;
    if ({dbg_state, retry_cnt} !== {ST_WAIT, 4'd1}) begin
      errors++;
      $display("FAIL restart_pre_timeout: state=%0d retry=%0d expected 1 1", dbg_state, retry_cnt);
    end
    pulse_restart();
    checks++;
    if ({dbg_state, retry_cnt, fail, pll_reset} !== {ST_RST, 4'd0, 2'b01}) begin
      errors++;
      $display("FAIL restart_vs_timeout: state=%0d retry=%0d fail=%b pr=%b expected 0 0 0 1", dbg_state, retry_cnt, fail, pll_reset);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (fail) saw_fail = 1'b1;
      if (!pll_reset && fall2_at == 0) fall2_at = k;
    end
    checks++;
    if ({saw_fail, fall2_at} !== {1'b0, 32'd4}) begin
      errors++;
      $display("FAIL restart_after_timeout: saw_fail=%b fell at %0d expected 0 4", saw_fail, fall2_at);
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = 0;
    pll_lock = 1'b1;
    pulse_restart();
    repeat (8) tick();
    checks++;
    if (dbg_state !== ST_STABLE) begin errors++; $display("FAIL midreset_pre: state=%0d expected 2", dbg_state); end
    reset = 1'b1;
    tick();
    checks++;
    if ({dbg_state, pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt} !== {ST_RST, 5'b11000, 4'd0}) begin
      errors++;
      $display("FAIL midreset_state: state=%0d pr=%b sr=%b rdy=%b fail=%b ll=%b retry=%0d expected 0 1 1 0 0 0 0",
               dbg_state, pll_reset, sys_rst, ready, fail, lock_lost, retry_cnt);
    end
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ready && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 13) begin errors++; $display("FAIL midreset_resequence: ready at %0d expected 13", rise_at); end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_glitch();
    test_lock_loss();
    test_timeout_fail();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
